pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline register for the MIPS core, generalising the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Provides valid/ready flow control with an optional 2-entry skid buffer, a synchronous stage flush and precise-exception merging.
- Merging rule: an older exception carried in from upstream beats an exception newly detected in this stage.
- Also holds a saturating back-pressure counter for performance monitoring.

---
 rtl/pipe_stage_reg_if.sv | 43 ++++
 rtl/pipe_stage_reg.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between an upstream producer, one elastic
// pipeline stage and its downstream consumer.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [31:0]       in_pc;
  logic              in_exc;
  logic [EXC_W-1:0]  in_exc_code;
  logic              in_isbd;
  logic              new_exc;
  logic [EXC_W-1:0]  new_exc_code;
  logic [31:0]       new_badvaddr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       out_pc;
  logic              out_exc;
  logic [EXC_W-1:0]  out_exc_code;
  logic [31:0]       out_badvaddr;
  logic              out_isbd;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, in_data, in_pc, in_exc, in_exc_code, in_isbd,
           new_exc, new_exc_code, new_badvaddr, out_ready,
    input  in_ready, out_valid, out_data, out_pc, out_exc, out_exc_code,
           out_badvaddr, out_isbd, occupancy, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, in_pc, in_exc, in_exc_code, in_isbd,
           new_exc, new_exc_code, new_badvaddr, out_ready,
    output in_ready, out_valid, out_data, out_pc, out_exc, out_exc_code,
           out_badvaddr, out_isbd, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic MIPS pipeline latch: valid/ready flow control with optional 2-entry
// skid buffer, synchronous flush, precise-exception merge and stall counter.
module pipe_stage_reg #(
  parameter int DATA_W   = 64,
  parameter int EXC_W    = 5,
  parameter int EXC_NONE = 15,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_stage_reg_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
    logic              exc;
    logic [EXC_W-1:0]  code;
    logic [31:0]       badvaddr;
    logic              isbd;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic entry_t idle_entry();
    entry_t e;
    e          = '0;
    e.code     = EXC_W'(EXC_NONE);
    return e;
  endfunction

  // An exception already in flight from an older stage outranks one found here.
  function automatic entry_t merge_exc(
    input logic [DATA_W-1:0] data,
    input logic [31:0]       pc,
    input logic              isbd,
    input logic              up_exc,
    input logic [EXC_W-1:0]  up_code,
    input logic              here_exc,
    input logic [EXC_W-1:0]  here_code,
    input logic [31:0]       here_badvaddr
  );
    entry_t e;
    e.data = data;
    e.pc   = pc;
    e.isbd = isbd;
    if (up_exc) begin
      e.exc      = 1'b1;
      e.code     = up_code;
      e.badvaddr = pc;
    end else if (here_exc) begin
      e.exc      = 1'b1;
      e.code     = here_code;
      e.badvaddr = here_badvaddr;
    end else begin
      e.exc      = 1'b0;
      e.code     = EXC_W'(EXC_NONE);
      e.badvaddr = pc;
    end
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  entry_t           cap, shown;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             out_valid, in_ready, in_xfer, out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || bus.out_ready);
  assign in_xfer   = bus.in_valid && in_ready && !bus.flush;
  assign out_xfer  = out_valid && bus.out_ready;
  assign cap       = merge_exc(bus.in_data, bus.in_pc, bus.in_isbd, bus.in_exc,
                               bus.in_exc_code, bus.new_exc, bus.new_exc_code,
                               bus.new_badvaddr);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = EMPTY;
      head_d  = idle_entry();
      skid_d  = idle_entry();
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            head_d  = cap;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            head_d = cap;
          end else if (in_xfer) begin
            skid_d  = cap;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low while full, so only a drain can happen here.
          if (out_xfer) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
    stall_d    = (out_valid && !bus.out_ready) ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  // Payload needs no reset: it is only visible through the valid mask below.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  always_comb begin
    shown = idle_entry();
    if (out_valid) shown = head_q;
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = shown.data;
  assign bus.out_pc       = shown.pc;
  assign bus.out_exc      = shown.exc;
  assign bus.out_exc_code = shown.code;
  assign bus.out_badvaddr = shown.badvaddr;
  assign bus.out_isbd     = shown.isbd;
  assign bus.occupancy    = state_q;
  assign bus.stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid-buffered instance and a single-entry,
// 4-bit-counter instance checked against a queue model plus directed literals.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] bad;
    logic        isbd;
  } ent_t;

  localparam ent_t RST_ENT = '{data: 64'd0, pc: 32'd0, exc: 1'b0, code: 5'd15,
                               bad: 32'd0, isbd: 1'b0};

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(64), .EXC_W(5), .CNT_W(16)) b0 ();
  pipe_stage_reg_if #(.DATA_W(64), .EXC_W(5), .CNT_W(4))  b1 ();

  pipe_stage_reg #(.DATA_W(64), .EXC_W(5), .EXC_NONE(15), .SKID(1), .CNT_W(16))
    u0 (.clk(clk), .rst(rst0), .bus(b0));
  pipe_stage_reg #(.DATA_W(64), .EXC_W(5), .EXC_NONE(15), .SKID(0), .CNT_W(4))
    u1 (.clk(clk), .rst(rst1), .bus(b1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mrg(input logic [63:0] d, input logic [31:0] pc,
                               input logic isbd, input logic ie, input logic [4:0] ic,
                               input logic ne, input logic [4:0] nc, input logic [31:0] nb);
    ent_t e;
    e.data = d;
    e.pc   = pc;
    e.isbd = isbd;
    if (ie) begin
      e.exc = 1'b1; e.code = ic; e.bad = pc;
    end else if (ne) begin
      e.exc = 1'b1; e.code = nc; e.bad = nb;
    end else begin
      e.exc = 1'b0; e.code = 5'd15; e.bad = pc;
    end
    return e;
  endfunction

  // Reference model: a FIFO of captured entries per instance.
  ent_t        m0[$];
  ent_t        m1[$];
  int unsigned sc0, sc1;

  always @(posedge clk or negedge rst0) begin
    if (!rst0) begin
      m0.delete();
      sc0 <= 0;
    end else begin
      if (m0.size() > 0 && !b0.out_ready) sc0 <= (sc0 == 65535) ? sc0 : sc0 + 1;
      if (b0.flush) m0.delete();
      else begin
        case (m0.size())
          0: if (b0.in_valid) m0.push_back(mrg(b0.in_data, b0.in_pc, b0.in_isbd, b0.in_exc,
                                                b0.in_exc_code, b0.new_exc, b0.new_exc_code,
                                                b0.new_badvaddr));
          1: begin
            if (b0.out_ready) void'(m0.pop_front());
            if (b0.in_valid) m0.push_back(mrg(b0.in_data, b0.in_pc, b0.in_isbd, b0.in_exc,
                                              b0.in_exc_code, b0.new_exc, b0.new_exc_code,
                                              b0.new_badvaddr));
          end
          default: if (b0.out_ready) void'(m0.pop_front());
        endcase
      end
    end
  end

  always @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      m1.delete();
      sc1 <= 0;
    end else begin
      if (m1.size() > 0 && !b1.out_ready) sc1 <= (sc1 == 15) ? sc1 : sc1 + 1;
      if (b1.flush) m1.delete();
      else if (m1.size() == 0) begin
        if (b1.in_valid) m1.push_back(mrg(b1.in_data, b1.in_pc, b1.in_isbd, b1.in_exc,
                                          b1.in_exc_code, b1.new_exc, b1.new_exc_code,
                                          b1.new_badvaddr));
      end else if (b1.out_ready) begin
        void'(m1.pop_front());
        if (b1.in_valid) m1.push_back(mrg(b1.in_data, b1.in_pc, b1.in_isbd, b1.in_exc,
                                          b1.in_exc_code, b1.new_exc, b1.new_exc_code,
                                          b1.new_badvaddr));
      end
    end
  end

  function automatic ent_t hd0();
    return (m0.size() > 0) ? m0[0] : RST_ENT;
  endfunction

  function automatic ent_t hd1();
    return (m1.size() > 0) ? m1[0] : RST_ENT;
  endfunction

  task automatic cmp(input string t, input ent_t e, input logic ev, input logic er,
                     input int eo, input int unsigned es, input logic av, input logic ar,
                     input logic [1:0] ao, input logic [63:0] as, input ent_t a);
    chk({t, ".out_valid"}, 64'(av), 64'(ev));
    chk({t, ".in_ready"}, 64'(ar), 64'(er));
    chk({t, ".occupancy"}, 64'(ao), 64'(eo));
    chk({t, ".stall_cnt"}, as, 64'(es));
    chk({t, ".out_data"}, a.data, e.data);
    chk({t, ".out_pc"}, 64'(a.pc), 64'(e.pc));
    chk({t, ".out_exc"}, 64'(a.exc), 64'(e.exc));
    chk({t, ".out_exc_code"}, 64'(a.code), 64'(e.code));
    chk({t, ".out_badvaddr"}, 64'(a.bad), 64'(e.bad));
    chk({t, ".out_isbd"}, 64'(a.isbd), 64'(e.isbd));
  endtask

  always @(negedge clk) begin
    cmp("skid", hd0(), m0.size() > 0, m0.size() < 2, m0.size(), sc0,
        b0.out_valid, b0.in_ready, b0.occupancy, 64'(b0.stall_cnt),
        {b0.out_data, b0.out_pc, b0.out_exc, b0.out_exc_code, b0.out_badvaddr, b0.out_isbd});
    cmp("single", hd1(), m1.size() > 0, (m1.size() == 0) || b1.out_ready, m1.size(), sc1,
        b1.out_valid, b1.in_ready, b1.occupancy, 64'(b1.stall_cnt),
        {b1.out_data, b1.out_pc, b1.out_exc, b1.out_exc_code, b1.out_badvaddr, b1.out_isbd});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put0(input logic [63:0] d, input logic [31:0] pc, input logic isbd,
                      input logic ie, input logic [4:0] ic, input logic ne,
                      input logic [4:0] nc, input logic [31:0] nb);
    b0.in_valid = 1'b1; b0.in_data = d; b0.in_pc = pc; b0.in_isbd = isbd;
    b0.in_exc = ie; b0.in_exc_code = ic;
    b0.new_exc = ne; b0.new_exc_code = nc; b0.new_badvaddr = nb;
  endtask

  task automatic idle0();
    b0.in_valid = 1'b0; b0.in_exc = 1'b0; b0.new_exc = 1'b0; b0.in_isbd = 1'b0;
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    b0.flush = 1'b0; b0.out_ready = 1'b0; b0.in_data = '0; b0.in_pc = '0;
    b0.in_exc_code = '0; b0.new_exc_code = '0; b0.new_badvaddr = '0;
    idle0();
    b1.flush = 1'b0; b1.in_valid = 1'b0; b1.in_data = '0; b1.in_pc = '0;
    b1.in_exc = 1'b0; b1.in_exc_code = '0; b1.in_isbd = 1'b0; b1.new_exc = 1'b0;
    b1.new_exc_code = '0; b1.new_badvaddr = '0; b1.out_ready = 1'b0;
    step(); step();
    chk("rst.out_valid", 64'(b0.out_valid), 64'd0);
    chk("rst.occupancy", 64'(b0.occupancy), 64'd0);
    chk("rst.stall_cnt", 64'(b0.stall_cnt), 64'd0);
    chk("rst.out_exc_code", 64'(b0.out_exc_code), 64'd15);
    chk("rst.out_data", b0.out_data, 64'd0);
    rst0 = 1'b1; rst1 = 1'b1;
    chk("rst.in_ready_after_release", 64'(b0.in_ready), 64'd1);

    // Single pass
    b0.out_ready = 1'b1;
    put0(64'h1234, 32'h3000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step();
    idle0();
    chk("pass.out_valid", 64'(b0.out_valid), 64'd1);
    chk("pass.out_data", b0.out_data, 64'h1234);
    chk("pass.out_exc", 64'(b0.out_exc), 64'd0);
    chk("pass.out_exc_code", 64'(b0.out_exc_code), 64'd15);
    chk("pass.out_badvaddr", 64'(b0.out_badvaddr), 64'h3000);
    step();
    chk("pass.out_valid_after", 64'(b0.out_valid), 64'd0);

    // Back-pressure: A, B accepted, C held upstream
    b0.out_ready = 1'b0;
    put0(64'hA, 32'h4000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step();
    chk("bp.occ_after_A", 64'(b0.occupancy), 64'd1);
    put0(64'hB, 32'h4004, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step();
    chk("bp.occ_after_B", 64'(b0.occupancy), 64'd2);
    chk("bp.in_ready_after_B", 64'(b0.in_ready), 64'd0);
    chk("bp.head_A", b0.out_data, 64'hA);
    put0(64'hC, 32'h4008, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step(); step();
    chk("bp.stall_cnt", 64'(b0.stall_cnt), 64'd3);
    b0.out_ready = 1'b1;
    step();
    chk("bp.head_B", b0.out_data, 64'hB);
    chk("bp.in_ready_reopen", 64'(b0.in_ready), 64'd1);
    step();
    idle0();
    chk("bp.head_C", b0.out_data, 64'hC);
    chk("bp.head_C_valid", 64'(b0.out_valid), 64'd1);
    step();
    chk("bp.drained", 64'(b0.out_valid), 64'd0);
    chk("bp.stall_hold", 64'(b0.stall_cnt), 64'd3);

    // Exception merge priority
    put0(64'hE1, 32'h3008, 1'b0, 1'b1, 5'd4, 1'b1, 5'd12, 32'hDEAD);
    step();
    chk("exc.up_code", 64'(b0.out_exc_code), 64'd4);
    chk("exc.up_bad", 64'(b0.out_badvaddr), 64'h3008);
    chk("exc.up_flag", 64'(b0.out_exc), 64'd1);
    put0(64'hE2, 32'h300C, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 32'h1001);
    step();
    idle0();
    chk("exc.new_code", 64'(b0.out_exc_code), 64'd5);
    chk("exc.new_bad", 64'(b0.out_badvaddr), 64'h1001);
    chk("exc.new_isbd", 64'(b0.out_isbd), 64'd1);
    step();

    // Flush while full, with a same-cycle input
    b0.out_ready = 1'b0;
    put0(64'hD, 32'h5000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step();
    put0(64'hE, 32'h5004, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h77);
    step();
    chk("flush.occ_before", 64'(b0.occupancy), 64'd2);
    b0.flush = 1'b1;
    put0(64'hF, 32'h5008, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step();
    b0.flush = 1'b0;
    idle0();
    chk("flush.out_valid", 64'(b0.out_valid), 64'd0);
    chk("flush.occupancy", 64'(b0.occupancy), 64'd0);
    chk("flush.out_exc_code", 64'(b0.out_exc_code), 64'd15);
    chk("flush.in_ready", 64'(b0.in_ready), 64'd1);
    chk("flush.stall_kept", 64'(b0.stall_cnt), 64'd5);
    b0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush.no_ghost", 64'(b0.out_valid), 64'd0);
    end

    // Asynchronous reset while full
    b0.out_ready = 1'b0;
    put0(64'h61, 32'h6000, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step();
    put0(64'h62, 32'h6004, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    step();
    idle0();
    chk("arst.occ_before", 64'(b0.occupancy), 64'd2);
    #2 rst0 = 1'b0;
    #1;
    chk("arst.out_valid", 64'(b0.out_valid), 64'd0);
    chk("arst.occupancy", 64'(b0.occupancy), 64'd0);
    chk("arst.stall_cnt", 64'(b0.stall_cnt), 64'd0);
    chk("arst.out_data", b0.out_data, 64'd0);
    chk("arst.out_exc_code", 64'(b0.out_exc_code), 64'd15);
    step();
    rst0 = 1'b1;
    step();

    // Single-entry instance: saturation and same-cycle head replacement
    b1.in_valid = 1'b1; b1.in_data = 64'h51; b1.in_pc = 32'h7000;
    step();
    b1.in_valid = 1'b0;
    chk("s0.valid", 64'(b1.out_valid), 64'd1);
    for (int i = 0; i < 20; i++) step();
    chk("s0.stall_sat", 64'(b1.stall_cnt), 64'd15);
    chk("s0.in_ready_blocked", 64'(b1.in_ready), 64'd0);
    chk("s0.occupancy", 64'(b1.occupancy), 64'd1);
    b1.out_ready = 1'b1;
    b1.in_valid = 1'b1; b1.in_data = 64'h52; b1.in_pc = 32'h7004;
    #1;
    chk("s0.in_ready_comb", 64'(b1.in_ready), 64'd1);
    step();
    b1.in_valid = 1'b0;
    chk("s0.replaced", b1.out_data, 64'h52);
    chk("s0.replaced_pc", 64'(b1.out_pc), 64'h7004);
    chk("s0.occ_one", 64'(b1.occupancy), 64'd1);
    step();
    chk("s0.drained", 64'(b1.out_valid), 64'd0);
    chk("s0.stall_final", 64'(b1.stall_cnt), 64'd15);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
